// File: rtl/wptr_full_level.sv
// rtl/wptr_full_level.sv - async FIFO write-domain pointer, full/almost-full, level and overflow
module wptr_full_level #(
    parameter int ADDRSIZE = 4
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic [ADDRSIZE:0]   afull_thresh,
    input  logic                ovf_clr,
    output logic                wen,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                wafull,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf
);

    logic [ADDRSIZE:0] wbin_q, wbin_d;
    logic [ADDRSIZE:0] wptr_q, wptr_d;
    logic [ADDRSIZE:0] wlevel_q, wlevel_d;
    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] full_ptr;
    logic              wfull_q, wfull_d;
    logic              wafull_q, wafull_d;
    logic              wovf_q, wovf_d;

    // Gated only by the registered full flag, so wq2_rptr never reaches wen combinationally.
    assign wen = winc & ~wfull_q;

    always_comb begin
        rbin = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            rbin[i] = ^(wq2_rptr >> i);
        end
    end

    assign full_ptr = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};

    always_comb begin
        wbin_d   = wbin_q + {{ADDRSIZE{1'b0}}, wen};
        wptr_d   = (wbin_d >> 1) ^ wbin_d;
        wlevel_d = wbin_d - rbin;
        wfull_d  = (wptr_d == full_ptr);
        wafull_d = (wlevel_d >= afull_thresh);
        wovf_d   = wovf_q;
        if (winc && wfull_q) begin
            wovf_d = 1'b1;
        end else if (ovf_clr) begin
            wovf_d = 1'b0;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wlevel_q <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wlevel_q <= wlevel_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wovf_q   <= wovf_d;
        end
    end

    assign waddr  = wbin_q[ADDRSIZE-1:0];
    assign wptr   = wptr_q;
    assign wfull  = wfull_q;
    assign wafull = wafull_q;
    assign wlevel = wlevel_q;
    assign wovf   = wovf_q;

endmodule

// File: tb/tb_wptr_full_level.sv
// tb/tb_wptr_full_level.sv - scoreboard bench for wptr_full_level
module tb_wptr_full_level;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int MOD   = 32;

    logic          wclk = 1'b0;
    logic          wrst_n = 1'b0;
    logic          winc = 1'b0;
    logic [AW:0]   wq2_rptr = '0;
    logic [AW:0]   afull_thresh = 5'd12;
    logic          ovf_clr = 1'b0;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr;
    logic          wfull;
    logic          wafull;
    logic [AW:0]   wlevel;
    logic          wovf;

    wptr_full_level #(.ADDRSIZE(AW)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr),
        .afull_thresh(afull_thresh), .ovf_clr(ovf_clr), .wen(wen), .waddr(waddr),
        .wptr(wptr), .wfull(wfull), .wafull(wafull), .wlevel(wlevel), .wovf(wovf)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        int waddr;
        int wptr;
        int wfull;
        int wafull;
        int wlevel;
        int wovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference state: count of accepted writes, binary read position, sticky flags
    int m_wbin = 0;
    int m_rb   = 0;
    int m_full = 0;
    int m_ovf  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int gray(input int b);
        return ((b >> 1) ^ b) & (MOD - 1);
    endfunction

    task automatic do_reset();
        @(negedge wclk);
        winc   = 1'b1;
        #2 wrst_n = 1'b0;
        #1;
        check("rst_waddr", int'(waddr), 0);
        check("rst_wptr", int'(wptr), 0);
        check("rst_wlevel", int'(wlevel), 0);
        check("rst_flags", int'({wfull, wafull, wovf}), 0);
        check("rst_wen", int'(wen), 1);
        @(posedge wclk);
        @(negedge wclk);
        winc     = 1'b0;
        ovf_clr  = 1'b0;
        wq2_rptr = '0;
        wrst_n   = 1'b1;
        m_wbin = 0; m_rb = 0; m_full = 0; m_ovf = 0;
        @(posedge wclk);
        #1;
        // Idle edge after release: thresh 0 already raises wafull here
        check("rel_wafull", int'(wafull), (afull_thresh == 0) ? 1 : 0);
        check("rel_wlevel", int'(wlevel), 0);
    endtask

    task automatic step(input int inc, input int rb, input int clr);
        exp_t e;
        int   acc;
        int   lvl;
        exp_t got;
        @(negedge wclk);
        winc     = inc[0];
        ovf_clr  = clr[0];
        wq2_rptr = gray(rb % MOD);
        #1;
        acc = (inc != 0 && m_full == 0) ? 1 : 0;
        check("wen", int'(wen), acc);
        m_wbin = (m_wbin + acc) % MOD;
        m_rb   = rb % MOD;
        lvl    = (m_wbin - m_rb + MOD) % MOD;
        m_ovf  = (inc != 0 && m_full != 0) ? 1 : ((clr != 0) ? 0 : m_ovf);
        m_full = (lvl == DEPTH) ? 1 : 0;
        e.waddr  = m_wbin % DEPTH;
        e.wptr   = gray(m_wbin);
        e.wfull  = m_full;
        e.wafull = (lvl >= int'(afull_thresh)) ? 1 : 0;
        e.wlevel = lvl;
        e.wovf   = m_ovf;
        exp_q.push_back(e);
        @(posedge wclk);
        #1;
        if (exp_q.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            got = exp_q.pop_front();
            check("waddr", int'(waddr), got.waddr);
            check("wptr", int'(wptr), got.wptr);
            check("wfull", int'(wfull), got.wfull);
            check("wafull", int'(wafull), got.wafull);
            check("wlevel", int'(wlevel), got.wlevel);
            check("wovf", int'(wovf), got.wovf);
        end
        winc    = 1'b0;
        ovf_clr = 1'b0;
    endtask

    initial begin
        // Reset with winc held high, then first accept
        do_reset();
        step(1, 0, 0);
        check("first_wptr", int'(wptr), 5'b00001);
        check("first_waddr", int'(waddr), 1);

        // Fill to full with threshold 12
        afull_thresh = 5'd12;
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            step(1, 0, 0);
            if (i == 11) check("afull_pre12", int'(wafull), 0);
            if (i == 12) begin
                check("afull_at12", int'(wafull), 1);
                check("lvl_at12", int'(wlevel), 12);
            end
            if (i == 15) check("full_pre16", int'(wfull), 0);
        end
        check("full_wptr", int'(wptr), 5'b11000);
        check("full_lvl", int'(wlevel), 16);
        check("full_flag", int'(wfull), 1);
        check("full_waddr", int'(waddr), 0);

        // Overflow attempts while full
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0);
            check("ovf_hold_wptr", int'(wptr), 5'b11000);
            check("ovf_set", int'(wovf), 1);
        end
        step(1, 0, 1);
        check("ovf_set_wins", int'(wovf), 1);
        step(0, 0, 1);
        check("ovf_cleared", int'(wovf), 0);

        // Drain four entries, then 20 writes with the read pointer tracking
        for (int r = 1; r <= 4; r++) begin
            step(0, r, 0);
            check("drain_lvl", int'(wlevel), 16 - r);
            check("drain_full", int'(wfull), 0);
        end
        for (int i = 1; i <= 20; i++) begin
            step(1, 4 + i, 0);
            check("track_lvl", int'(wlevel), 12);
        end
        check("wrap_wptr", int'(wptr), gray(4));

        // Simultaneous write and read advance at level 15
        for (int i = 0; i < 3; i++) step(1, 24, 0);
        step(1, 25, 0);
        check("simul_lvl", int'(wlevel), 15);
        check("simul_full", int'(wfull), 0);

        // Threshold extremes
        afull_thresh = 5'd0;
        do_reset();
        step(0, 0, 0);
        check("thr0_afull", int'(wafull), 1);

        afull_thresh = 5'd16;
        do_reset();
        for (int i = 0; i < 16; i++) step(1, 0, 0);
        for (int r = 1; r <= 16; r++) step(0, r, 0);

        // Asynchronous reset mid-operation
        step(1, 16, 0);
        step(1, 16, 0);
        do_reset();

        check("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
